serial_subtractor_16bit: RTL

//  Bit-serial two's-complement subtractor: computes DIFF = A - B, one bit per clock,

---
 rtl/serial_subtractor_16bit.sv | 87 ++++++++
 1 files changed

// File: rtl/serial_subtractor_16bit.sv
// serial_subtractor_16bit: bit-serial A - B (A + ~B + 1) with one full-adder cell behind a start/done handshake
module serial_subtractor_16bit #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] diff_o,
  output logic             borrow_o,
  output logic             overflow_o
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state_q;
  logic [WIDTH-1:0] a_sh_q, b_sh_q, r_sh_q, r_sh_d, diff_q;
  logic [CW-1:0]    cnt_q;
  logic             carry_q, carry_d, s_d, a_msb_q, b_msb_q;
  logic             busy_q, done_q, borrow_q, overflow_q;
  // single full-adder cell on the current LSBs, subtrahend inverted
  always_comb begin
    s_d     = a_sh_q[0] ^ ~b_sh_q[0] ^ carry_q;
    carry_d = (a_sh_q[0] & ~b_sh_q[0]) | (a_sh_q[0] & carry_q) | (~b_sh_q[0] & carry_q);
    r_sh_d  = {s_d, r_sh_q[WIDTH-1:1]};
  end
  // control FSM with datapath shift and registered handshake/result outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      a_sh_q     <= '0;
      b_sh_q     <= '0;
      r_sh_q     <= '0;
      cnt_q      <= '0;
      carry_q    <= 1'b0;
      a_msb_q    <= 1'b0;
      b_msb_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      diff_q     <= '0;
      borrow_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start_i) begin
            state_q <= RUN;
            a_sh_q  <= a_i;
            b_sh_q  <= b_i;
            a_msb_q <= a_i[WIDTH-1];
            b_msb_q <= b_i[WIDTH-1];
            carry_q <= 1'b1;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        RUN: begin
          a_sh_q  <= a_sh_q >> 1;
          b_sh_q  <= b_sh_q >> 1;
          r_sh_q  <= r_sh_d;
          carry_q <= carry_d;
          cnt_q   <= cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_q    <= DONE;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            diff_q     <= r_sh_d;
            borrow_q   <= ~carry_d;
            overflow_q <= (a_msb_q != b_msb_q) && (s_d != a_msb_q);
          end
        end
        default: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
      endcase
    end
  end
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign diff_o     = diff_q;
  assign borrow_o   = borrow_q;
  assign overflow_o = overflow_q;
endmodule
